// File: rtl/bus_cycle_ctrl_pkg.sv
// Shared types for the bus cycle controller.
// T-state encoding plus the S1/S0 status codes.
package bus_cycle_ctrl_pkg;

    typedef enum logic [2:0] {
        TS_IDLE = 3'd0,
        TS_T1   = 3'd1,
        TS_T2   = 3'd2,
        TS_TW   = 3'd3,
        TS_T3   = 3'd4,
        TS_T4   = 3'd5
    } tstate_e;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_WRITE = 2'b01;
    localparam logic [1:0] ST_READ  = 2'b10;
    localparam logic [1:0] ST_FETCH = 2'b11;

    // Fetch wins over the write/read selection.
    function automatic logic [1:0] cycle_status(
        input logic wr,
        input logic fetch
    );
        if (fetch) begin
            return ST_FETCH;
        end
        return wr ? ST_WRITE : ST_READ;
    endfunction

endpackage

// File: rtl/bus_cycle_ctrl_if.sv
// Request and multiplexed bus signals of the bus cycle controller.
// master = the controller, slave = the host/bus side.
interface bus_cycle_ctrl_if;

    logic        req;
    logic        wr;
    logic        io;
    logic        fetch;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  ad_in;
    logic        ready;

    logic        busy;
    logic        done;
    logic [7:0]  rdata;
    logic [7:0]  a_hi;
    logic [7:0]  ad_out;
    logic        ad_oe;
    logic        ale;
    logic        rd_n;
    logic        wr_n;
    logic        io_m;
    logic        s1;
    logic        s0;

    modport master (
        input  req, wr, io, fetch, addr, wdata, ad_in, ready,
        output busy, done, rdata, a_hi, ad_out, ad_oe,
        output ale, rd_n, wr_n, io_m, s1, s0
    );

    modport slave (
        output req, wr, io, fetch, addr, wdata, ad_in, ready,
        input  busy, done, rdata, a_hi, ad_out, ad_oe,
        input  ale, rd_n, wr_n, io_m, s1, s0
    );

endinterface

// File: rtl/bus_cycle_ctrl.sv
// 8085-style multiplexed bus cycle FSM (T1/T2/TW/T3/T4).
// Strobes decode from the registered state and latched request.
module bus_cycle_ctrl
    import bus_cycle_ctrl_pkg::*;
(
    input logic              clk,
    input logic              rst,
    bus_cycle_ctrl_if.master bus
);

    localparam logic [2:0] IDLE = TS_IDLE;
    localparam logic [2:0] T1   = TS_T1;
    localparam logic [2:0] T2   = TS_T2;
    localparam logic [2:0] TW   = TS_TW;
    localparam logic [2:0] T3   = TS_T3;
    localparam logic [2:0] T4   = TS_T4;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;
    logic        wr_q;
    logic        io_q;
    logic        fetch_q;
    logic        done_q;
    logic        is_rd;
    logic        in_data;

    assign is_rd   = fetch_q | ~wr_q;
    assign in_data = (state == T2) || (state == TW) || (state == T3);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req) state_nxt = T1;
            T1:      state_nxt = T2;
            T2, TW:  state_nxt = bus.ready ? T3 : TW;
            T3:      state_nxt = fetch_q ? T4 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            io_q    <= 1'b0;
            fetch_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= (state == T3);
            if (state == IDLE && bus.req) begin
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                wr_q    <= bus.wr;
                io_q    <= bus.io;
                fetch_q <= bus.fetch;
            end
            if (state == T3 && is_rd) begin
                rdata_q <= bus.ad_in;
            end
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;
    assign bus.a_hi  = addr_q[15:8];

    always_comb begin
        bus.ale    = 1'b0;
        bus.rd_n   = 1'b1;
        bus.wr_n   = 1'b1;
        bus.ad_oe  = 1'b0;
        bus.ad_out = 8'h00;
        bus.io_m   = 1'b0;
        {bus.s1, bus.s0} = ST_IDLE;
        if (state != IDLE) begin
            bus.io_m = io_q & ~fetch_q;
            {bus.s1, bus.s0} = cycle_status(wr_q, fetch_q);
        end
        if (state == T1) begin
            bus.ale    = 1'b1;
            bus.ad_out = addr_q[7:0];
            bus.ad_oe  = 1'b1;
        end else if (in_data && is_rd) begin
            bus.rd_n   = 1'b0;
            bus.ad_out = addr_q[7:0];
        end else if (in_data) begin
            bus.wr_n   = 1'b0;
            bus.ad_out = wdata_q;
            bus.ad_oe  = 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Randomized scoreboard bench for bus_cycle_ctrl.
// Driver pushes expected cycles; a negedge monitor pops on done.
module tb_bus_cycle_ctrl;
    import bus_cycle_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    bus_cycle_ctrl_if bus();

    bus_cycle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         start;
        int         n;
        logic       rd;
        logic       fetch;
        logic [7:0] ahi;
        logic [7:0] alo;
        logic       iom;
        logic [1:0] st;
        logic [7:0] wd;
        logic [7:0] rdata;
    } exp_t;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    logic [7:0] last_rd = 8'h00;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic garbage();
        bus.req   = 1'($urandom);
        bus.wr    = 1'($urandom);
        bus.io    = 1'($urandom);
        bus.fetch = 1'($urandom);
        bus.addr  = 16'($urandom);
        bus.wdata = 8'($urandom);
        bus.ready = 1'($urandom);
        bus.ad_in = 8'($urandom);
    endtask

    task automatic wait_idle();
        int g = 0;
        while (bus.busy === 1'b1 && g < 100) begin
            garbage();
            @(negedge clk);
            g++;
        end
        if (g >= 100) check("idle_wait_timeout", 1, 0);
    endtask

    task automatic check_reset_vec(input string name);
        check(name,
              {bus.busy, bus.done, bus.ale, bus.rd_n, bus.wr_n, bus.ad_oe,
               bus.io_m, bus.s1, bus.s0, bus.rdata, bus.a_hi, bus.ad_out},
              {9'b000110000, 24'h0});
    endtask

    // Called at a negedge; returns at the negedge after T3.
    task automatic issue(input logic [15:0] addr, input logic [7:0] wd,
                         input logic wr, input logic io, input logic fetch,
                         input int n, input logic [7:0] data);
        exp_t e;
        wait_idle();
        e.start = cyc;
        e.n     = n;
        e.rd    = fetch | ~wr;
        e.fetch = fetch;
        e.ahi   = addr[15:8];
        e.alo   = addr[7:0];
        e.iom   = io & ~fetch;
        e.st    = fetch ? ST_FETCH : (wr ? ST_WRITE : ST_READ);
        e.wd    = wd;
        e.rdata = e.rd ? data : last_rd;
        last_rd = e.rdata;
        sb.push_back(e);
        bus.req   = 1'b1;
        bus.addr  = addr;
        bus.wdata = wd;
        bus.wr    = wr;
        bus.io    = io;
        bus.fetch = fetch;
        bus.ready = 1'($urandom);
        bus.ad_in = ~data;
        @(negedge clk);
        garbage();
        bus.ad_in = ~data;
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            garbage();
            bus.ready = (k == n);
            bus.ad_in = ~data;
        end
        @(negedge clk);
        garbage();
        bus.ad_in = data;
        @(negedge clk);
        bus.req   = 1'b0;
        bus.ad_in = ~data;
    endtask

    task automatic reset_mid_write();
        wait_idle();
        bus.req   = 1'b1;
        bus.wr    = 1'b1;
        bus.fetch = 1'b0;
        bus.io    = 1'($urandom);
        bus.addr  = 16'($urandom);
        bus.wdata = 8'($urandom);
        @(negedge clk);
        bus.req   = 1'b0;
        bus.ready = 1'b0;
        repeat (3) @(negedge clk);
        check("wr_n_low_in_tw", bus.wr_n, 0);
        #2 rst = 1'b1;
        #1 check_reset_vec("reset_in_tw");
        last_rd = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    int         ale_cnt;
    int         rd_cnt;
    int         wr_cnt;
    logic       oe_ok;
    logic [7:0] cap_ahi;
    logic [7:0] cap_alo;
    logic [7:0] cap_wd;
    logic       cap_iom;
    logic [1:0] cap_st;
    logic [7:0] cur_rd = 8'h00;

    task automatic clear_mon();
        ale_cnt = 0;
        rd_cnt  = 0;
        wr_cnt  = 0;
        oe_ok   = 1'b1;
        cap_ahi = 8'h00;
        cap_alo = 8'h00;
        cap_wd  = 8'h00;
        cap_iom = 1'b0;
        cap_st  = 2'b00;
    endtask

    initial clear_mon();

    always @(negedge clk) begin
        if (rst) begin
            clear_mon();
            cur_rd = 8'h00;
        end else begin
            int s;
            exp_t e;
            s = int'(bus.ale) + int'(!bus.rd_n) + int'(!bus.wr_n);
            check("strobe_exclusive", s <= 1, 1);
            if (!bus.busy) check("idle_status", {bus.s1, bus.s0}, ST_IDLE);
            if (bus.ale) begin
                ale_cnt++;
                cap_ahi = bus.a_hi;
                cap_alo = bus.ad_out;
                cap_iom = bus.io_m;
                cap_st  = {bus.s1, bus.s0};
                oe_ok   = oe_ok & bus.ad_oe;
            end
            if (!bus.rd_n) rd_cnt++;
            if (!bus.wr_n) begin
                wr_cnt++;
                cap_wd = bus.ad_out;
                oe_ok  = oe_ok & bus.ad_oe;
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("done_latency", cyc - e.start, 4 + e.n);
                    check("rdata", bus.rdata, e.rdata);
                    check("ale_count", ale_cnt, 1);
                    check("a_hi_t1", cap_ahi, e.ahi);
                    check("ad_out_t1", cap_alo, e.alo);
                    check("io_m", cap_iom, e.iom);
                    check("s1s0", cap_st, e.st);
                    check("rd_n_cycles", rd_cnt, e.rd ? 2 + e.n : 0);
                    check("wr_n_cycles", wr_cnt, e.rd ? 0 : 2 + e.n);
                    check("busy_at_done", bus.busy, e.fetch);
                    check("ad_oe_drive", oe_ok, 1);
                    if (!e.rd) check("write_data", cap_wd, e.wd);
                    cur_rd = e.rdata;
                end
                clear_mon();
            end else begin
                check("rdata_hold", bus.rdata, cur_rd);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        bus.req   = 1'b0;
        bus.wr    = 1'b0;
        bus.io    = 1'b0;
        bus.fetch = 1'b0;
        bus.addr  = 16'h0;
        bus.wdata = 8'h0;
        bus.ad_in = 8'h0;
        bus.ready = 1'b0;
        @(negedge clk);
        check_reset_vec("reset_initial");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(16'h2050, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h3C);
        issue(16'h0081, 8'hA5, 1'b1, 1'b1, 1'b0, 0, 8'h77);
        issue(16'h1234, 8'h00, 1'b0, 1'b0, 1'b0, 3, 8'h9E);
        issue(16'hC0DE, 8'h11, 1'b1, 1'b1, 1'b1, 0, 8'h43);
        issue(16'h4000, 8'h22, 1'b0, 1'b1, 1'b0, 1, 8'h5A);
        reset_mid_write();
        check("a_hi_after_reset", bus.a_hi, 8'h00);
        issue(16'h8899, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'hE1);

        for (int i = 0; i < 40; i++) begin
            issue(16'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom_range(3, 0) == 0), int'($urandom_range(4, 0)),
                  8'($urandom));
            if ($urandom_range(2, 0) == 0) begin
                repeat (int'($urandom_range(3, 1))) @(negedge clk);
            end
        end

        for (int g = 0; g < 50 && sb.size() != 0; g++) @(negedge clk);
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_cycle_ctrl.md
BUS_CYCLE_CTRL -- requirements
Module: bus_cycle_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock, one clk period = one T-state; rst input 1, asynchronous active-high reset.
REQ-002 Inputs: req 1 (start bus cycle); wr 1 (1=write, 0=read); io 1 (1=I/O space); fetch 1 (opcode fetch); addr 16; wdata 8; ad_in 8 (external AD bus sampled); ready 1 (external READY).
REQ-003 Outputs: busy 1 (cycle in progress); done 1 (one-cycle completion pulse); rdata 8 (read result); a_hi 8 (A15..A8); ad_out 8 (AD7..AD0 drive value); ad_oe 1 (AD bus drive enable); ale 1; rd_n 1; wr_n 1; io_m 1; s1 1; s0 1.

Function
REQ-004 FSM states SHALL be IDLE, T1, T2, TW, T3, T4; busy=1 in every state except IDLE.
REQ-005 In IDLE with req=1, the block SHALL latch addr, wdata, wr, io and fetch, then enter T1 next cycle; req outside IDLE SHALL be ignored.
REQ-006 Cycle type priority: fetch=1 forces a read with io_m=0 and S1S0=11, regardless of wr and io; otherwise a read gives S1S0=10 and a write gives S1S0=01; IDLE gives S1S0=00.
REQ-007 T1: ale=1, a_hi=addr[15:8], ad_out=addr[7:0], ad_oe=1, io_m and S1S0 valid, rd_n=wr_n=1.
REQ-008 T2 read: ale=0, ad_oe=0, rd_n=0. T2 write: ale=0, ad_out=wdata, ad_oe=1, wr_n=0.
REQ-009 ready SHALL be sampled on the edge ending T2 and on the edge ending each TW: 0 -> TW, 1 -> T3; the number of TW states is unbounded.
REQ-010 TW and T3 SHALL hold all T2 strobe, data and address values unchanged.
REQ-011 Read: rdata SHALL be loaded from ad_in on the edge ending T3; rd_n SHALL return to 1 in the following cycle.
REQ-012 done SHALL be 1 for exactly the single cycle following T3, for all cycle types; for reads, rdata is valid in that cycle and holds until the next read completes.
REQ-013 After T3: fetch -> T4 (ad_oe=0, strobes inactive, a_hi held, done=1) -> IDLE; non-fetch -> IDLE (done=1 in that IDLE cycle).
REQ-014 Latency: a zero-wait read or write SHALL take req cycle + T1, T2, T3 (done in cycle 4); each TW adds one cycle; a fetch adds T4, but done still falls in cycle 4.
REQ-015 a_hi SHALL hold its last driven value in IDLE; ale, rd_n and wr_n SHALL never be active simultaneously.

Reset
REQ-016 rst=1 SHALL immediately force: state IDLE, busy=0, done=0, rdata=8'h00, a_hi=8'h00, ad_out=8'h00, ad_oe=0, ale=0, rd_n=1, wr_n=1, io_m=0, s1=0, s0=0.
REQ-017 Reset during any T-state SHALL abort the cycle with no done pulse and no rdata update; the first req after rst deasserts SHALL be served normally.

Structure
REQ-018 A shared package SHALL hold the T-state enum and the S1S0 status constants (IDLE 00, WRITE 01, READ 10, FETCH 11).
REQ-019 The block SHALL be a single FSM module with no sub-modules; all outputs SHALL be registered or decoded from the registered state and latched request only.

Verification
REQ-020 Memory read, addr=16'h2050, ready=1, ad_in=8'h3C in T3 -> ale in cycle 1 with a_hi=20 and ad_out=50; rd_n low in cycles 2-3; done and rdata=3C in cycle 4; S1S0=10, io_m=0.
REQ-021 I/O write, io=1, addr=16'h0081, wdata=8'hA5, ready=1 -> io_m=1, S1S0=01, ad_out=A5 with ad_oe=1 and wr_n=0 in T2-T3, done in cycle 4.
REQ-022 Read with ready=0 for 3 samples -> three TW states, rd_n low for 5 cycles, done in cycle 7, rdata captured only at the end of T3.
REQ-023 Opcode fetch, fetch=1, wr=1, io=1, ad_in=8'h43 -> S1S0=11, io_m=0, read strobes, T4 present, rdata=43, busy drops after T4.
REQ-024 rst asserted in TW of a write -> wr_n=1, ad_oe=0 and busy=0 immediately, no done pulse; a following read completes normally.
REQ-025 req held high continuously -> back-to-back cycles separated by exactly one IDLE cycle; req during busy is never latched.
